// File: rtl/dma_pkg.sv
// Shared DMA definitions: pop-side FSM encoding and byte-lane offset sizing.
package dma_pkg;

  // Destination-side reader states, 3-bit encoded.
  typedef enum logic [2:0] {
    POP_IDLE  = 3'd0,
    POP_REQ   = 3'd1,
    POP_WAIT  = 3'd2,
    POP_WRITE = 3'd3,
    POP_DONE  = 3'd4
  } pop_state_e;

  // Width of the byte-lane offset inside one bus word (at least 1 bit).
  function automatic int off_wd(input int be_wd);
    return (be_wd > 1) ? $clog2(be_wd) : 1;
  endfunction

  // Byte-lane offset width for the default 32-bit data path.
  localparam int DMA_OFF_WD = 2;

endpackage

// File: rtl/dma_strb_gen.sv
// Combinational beat sizer: from the lane offset and the bytes still to move,
// produce the byte count of this beat and its lane strobe.
module dma_strb_gen
  import dma_pkg::*;
#(
  parameter int BE_WD  = 4,
  parameter int LEN_WD = 16,
  parameter int OFF_WD = DMA_OFF_WD
) (
  input  logic [OFF_WD-1:0] off,
  input  logic [LEN_WD-1:0] rem,
  output logic [OFF_WD:0]   nb,
  output logic [BE_WD-1:0]  strb
);

  logic [OFF_WD:0]   avail;
  logic [OFF_WD+1:0] lane_lo;
  logic [OFF_WD+1:0] lane_hi;

  // Beat size is the lanes left in this word, clipped to the remaining bytes.
  always_comb begin
    avail = (OFF_WD+1)'(BE_WD) - {1'b0, off};
    if (rem < LEN_WD'(avail)) begin
      nb = rem[OFF_WD:0];
    end else begin
      nb = avail;
    end
  end

  // Strobe covers lanes [off, off+nb): ((1<<nb)-1) << off.
  always_comb begin
    strb    = '0;
    lane_lo = {2'b00, off};
    lane_hi = {2'b00, off} + {1'b0, nb};
    for (int i = 0; i < BE_WD; i++) begin
      if (((OFF_WD+2)'(i) >= lane_lo) && ((OFF_WD+2)'(i) < lane_hi)) begin
        strb[i] = 1'b1;
      end else begin
        strb[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_pop_ctrl.sv
// Destination-side reader of the per-channel DMA byte buffer: requests one
// word at a time, then forwards it as a word-aligned strobed write.
module dma_pop_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int BE_WD   = DATA_WD / 8,
  parameter int ADDR_WD = 32,
  parameter int LEN_WD  = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic [ADDR_WD-1:0] dst_addr_i,
  input  logic [LEN_WD-1:0]  len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               buf_rready_o,
  output logic [BE_WD-1:0]   buf_rbe_o,
  input  logic               buf_rvalid_i,
  input  logic [DATA_WD-1:0] buf_rdata_i,
  output logic               wr_valid_o,
  output logic [ADDR_WD-1:0] wr_addr_o,
  output logic [DATA_WD-1:0] wr_data_o,
  output logic [BE_WD-1:0]   wr_strb_o,
  input  logic               wr_ready_i
);

  localparam int OFF_WD = off_wd(BE_WD);

  pop_state_e         state_r;
  pop_state_e         state_nxt;
  logic [ADDR_WD-1:0] addr_r;
  logic [LEN_WD-1:0]  rem_r;
  logic [DATA_WD-1:0] data_r;

  logic [OFF_WD:0]    nb;
  logic [BE_WD-1:0]   strb;
  logic [DATA_WD-1:0] lane_mask;
  logic [ADDR_WD-1:0] addr_algn;
  logic [LEN_WD-1:0]  rem_after;

  dma_strb_gen #(
    .BE_WD  (BE_WD),
    .LEN_WD (LEN_WD),
    .OFF_WD (OFF_WD)
  ) u_strb_gen (
    .off  (addr_r[OFF_WD-1:0]),
    .rem  (rem_r),
    .nb   (nb),
    .strb (strb)
  );

  assign addr_algn = {addr_r[ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
  assign rem_after = rem_r - LEN_WD'(nb);

  // Expand the lane strobe to a bit mask so unrequested lanes capture as zero.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < BE_WD; b++) begin
      lane_mask[b*8 +: 8] = {8{strb[b]}};
    end
  end

  // State register; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= POP_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode; only one beat is ever in flight.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      POP_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_nxt = POP_REQ;
          end else begin
            state_nxt = POP_DONE;
          end
        end else begin
          state_nxt = POP_IDLE;
        end
      end
      POP_REQ: begin
        state_nxt = POP_WAIT;
      end
      POP_WAIT: begin
        if (buf_rvalid_i) begin
          state_nxt = POP_WRITE;
        end else begin
          state_nxt = POP_WAIT;
        end
      end
      POP_WRITE: begin
        if (wr_ready_i) begin
          if (rem_after == '0) begin
            state_nxt = POP_DONE;
          end else begin
            state_nxt = POP_REQ;
          end
        end else begin
          state_nxt = POP_WRITE;
        end
      end
      POP_DONE: begin
        state_nxt = POP_IDLE;
      end
      default: begin
        state_nxt = POP_IDLE;
      end
    endcase
  end

  // Descriptor, progress and captured-data registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_r <= '0;
      rem_r  <= '0;
      data_r <= '0;
    end else begin
      case (state_r)
        POP_IDLE: begin
          if (start_i && (len_i != '0)) begin
            addr_r <= dst_addr_i;
            rem_r  <= len_i;
          end
        end
        POP_WAIT: begin
          if (buf_rvalid_i) begin
            data_r <= buf_rdata_i & lane_mask;
          end
        end
        POP_WRITE: begin
          if (wr_ready_i) begin
            addr_r <= addr_algn + ADDR_WD'(BE_WD);
            rem_r  <= rem_after;
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  // Outputs are decoded only from state and registers.
  assign busy_o       = (state_r != POP_IDLE);
  assign done_o       = (state_r == POP_DONE);
  assign buf_rready_o = (state_r == POP_REQ);
  assign buf_rbe_o    = (state_r == POP_REQ) ? strb : '0;
  assign wr_valid_o   = (state_r == POP_WRITE);
  assign wr_addr_o    = (state_r == POP_WRITE) ? addr_algn : '0;
  assign wr_data_o    = (state_r == POP_WRITE) ? data_r : '0;
  assign wr_strb_o    = (state_r == POP_WRITE) ? strb : '0;

endmodule

// File: tb/tb_dma_pop_ctrl.sv
// Directed bench for dma_pop_ctrl: aligned, unaligned, sub-word, wrap,
// back-pressure, zero-length, start-while-busy and mid-transfer reset.
module tb_dma_pop_ctrl;

  logic        clk_i;
  logic        rstn_i;
  logic        start_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        buf_rready_o;
  logic [3:0]  buf_rbe_o;
  logic        buf_rvalid_i;
  logic [31:0] buf_rdata_i;
  logic        wr_valid_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_strb_o;
  logic        wr_ready_i;

  int n_asrt;
  int n_fail;

  dma_pop_ctrl #(
    .DATA_WD (32),
    .BE_WD   (4),
    .ADDR_WD (32),
    .LEN_WD  (16)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .dst_addr_i   (dst_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .buf_rready_o (buf_rready_o),
    .buf_rbe_o    (buf_rbe_o),
    .buf_rvalid_i (buf_rvalid_i),
    .buf_rdata_i  (buf_rdata_i),
    .wr_valid_o   (wr_valid_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_strb_o    (wr_strb_o),
    .wr_ready_i   (wr_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] l);
    start_i    = 1'b1;
    dst_addr_i = a;
    len_i      = l;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  // Entered at the negedge where REQ is visible; returns at the negedge after the write fire.
  task automatic run_beat(input logic [3:0] e_strb, input logic [31:0] e_addr,
                          input logic [31:0] rdata, input int wait_cyc, input int bp_cyc,
                          input bit last, input bit poke);
    logic [31:0] e_data;
    e_data = rdata & byte_mask(e_strb);
    chk("req_rready", {63'd0, buf_rready_o}, 64'd1);
    chk("req_rbe", {60'd0, buf_rbe_o}, {60'd0, e_strb});
    chk("req_busy", {63'd0, busy_o}, 64'd1);
    @(negedge clk_i);
    if (poke) begin
      start_i    = 1'b1;
      dst_addr_i = 32'h0000_0500;
      len_i      = 16'd4;
    end
    for (int i = 0; i < wait_cyc; i++) begin
      chk("wait_rready", {63'd0, buf_rready_o}, 64'd0);
      chk("wait_wvalid", {63'd0, wr_valid_o}, 64'd0);
      @(negedge clk_i);
      start_i = 1'b0;
    end
    start_i      = 1'b0;
    buf_rvalid_i = 1'b1;
    buf_rdata_i  = rdata;
    wr_ready_i   = (bp_cyc == 0);
    @(negedge clk_i);
    buf_rvalid_i = 1'b0;
    buf_rdata_i  = 32'h5A5A_5A5A;
    chk("wr_valid", {63'd0, wr_valid_o}, 64'd1);
    chk("wr_addr", {32'd0, wr_addr_o}, {32'd0, e_addr});
    chk("wr_data", {32'd0, wr_data_o}, {32'd0, e_data});
    chk("wr_strb", {60'd0, wr_strb_o}, {60'd0, e_strb});
    chk("wr_rready", {63'd0, buf_rready_o}, 64'd0);
    for (int i = 0; i < bp_cyc; i++) begin
      buf_rvalid_i = (i == 1);
      buf_rdata_i  = 32'hCAFE_F00D;
      @(negedge clk_i);
      buf_rvalid_i = 1'b0;
      chk("bp_valid", {63'd0, wr_valid_o}, 64'd1);
      chk("bp_addr", {32'd0, wr_addr_o}, {32'd0, e_addr});
      chk("bp_data", {32'd0, wr_data_o}, {32'd0, e_data});
      chk("bp_strb", {60'd0, wr_strb_o}, {60'd0, e_strb});
      chk("bp_rready", {63'd0, buf_rready_o}, 64'd0);
    end
    wr_ready_i = 1'b1;
    @(negedge clk_i);
    if (last) begin
      chk("end_done", {63'd0, done_o}, 64'd1);
      chk("end_busy", {63'd0, busy_o}, 64'd1);
      chk("end_rready", {63'd0, buf_rready_o}, 64'd0);
      chk("end_wvalid", {63'd0, wr_valid_o}, 64'd0);
      @(negedge clk_i);
      chk("idle_done", {63'd0, done_o}, 64'd0);
      chk("idle_busy", {63'd0, busy_o}, 64'd0);
    end else begin
      chk("mid_done", {63'd0, done_o}, 64'd0);
    end
  endtask

  initial begin
    n_asrt       = 0;
    n_fail       = 0;
    rstn_i       = 1'b0;
    start_i      = 1'b0;
    dst_addr_i   = 32'h0;
    len_i        = 16'd0;
    buf_rvalid_i = 1'b0;
    buf_rdata_i  = 32'h0;
    wr_ready_i   = 1'b1;

    // Reset state
    @(negedge clk_i);
    chk("rst_ctl", {54'd0, busy_o, done_o, buf_rready_o, buf_rbe_o, wr_valid_o, wr_strb_o}, 64'd0);
    chk("rst_wr", {wr_addr_o, wr_data_o}, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rel_busy", {63'd0, busy_o}, 64'd0);

    // Aligned: 0x100, len 8
    start_xfer(32'h0000_0100, 16'd8);
    run_beat(4'b1111, 32'h0000_0100, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
    run_beat(4'b1111, 32'h0000_0104, 32'h5566_7788, 2, 0, 1'b1, 1'b0);

    // Unaligned: 0x103, len 6
    start_xfer(32'h0000_0103, 16'd6);
    run_beat(4'b1000, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b0);
    run_beat(4'b1111, 32'h0000_0104, 32'h0123_4567, 0, 0, 1'b0, 1'b0);
    run_beat(4'b0001, 32'h0000_0108, 32'h89AB_CDEF, 3, 0, 1'b1, 1'b0);

    // Sub-word: 0x102, len 1
    start_xfer(32'h0000_0102, 16'd1);
    run_beat(4'b0100, 32'h0000_0100, 32'h1122_3344, 0, 0, 1'b1, 1'b0);

    // Address wrap: 0xFFFFFFFE, len 4
    start_xfer(32'hFFFF_FFFE, 16'd4);
    run_beat(4'b1100, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 0, 0, 1'b0, 1'b0);
    run_beat(4'b0011, 32'h0000_0000, 32'h3C3C_3C3C, 0, 0, 1'b1, 1'b0);

    // Back-pressure on beat 1 with stray rvalid pulses
    start_xfer(32'h0000_0200, 16'd8);
    run_beat(4'b1111, 32'h0000_0200, 32'hF0E1_D2C3, 1, 5, 1'b0, 1'b0);
    run_beat(4'b1111, 32'h0000_0204, 32'hB4A5_9687, 0, 0, 1'b1, 1'b0);

    // Zero length
    start_xfer(32'h0000_0600, 16'd0);
    chk("zl_done", {63'd0, done_o}, 64'd1);
    chk("zl_busy", {63'd0, busy_o}, 64'd1);
    chk("zl_rready", {63'd0, buf_rready_o}, 64'd0);
    @(negedge clk_i);
    chk("zl_idle_done", {63'd0, done_o}, 64'd0);
    chk("zl_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("zl_idle_rready", {63'd0, buf_rready_o}, 64'd0);

    // Start pulsed while busy
    start_xfer(32'h0000_0300, 16'd8);
    run_beat(4'b1111, 32'h0000_0300, 32'h0F0F_0F0F, 2, 0, 1'b0, 1'b1);
    run_beat(4'b1111, 32'h0000_0304, 32'hF0F0_F0F0, 0, 0, 1'b1, 1'b0);

    // Reset in WAIT
    start_xfer(32'h0000_0400, 16'd8);
    chk("rw_rready", {63'd0, buf_rready_o}, 64'd1);
    @(negedge clk_i);
    chk("rw_busy_pre", {63'd0, busy_o}, 64'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("rw_async_ctl", {54'd0, busy_o, done_o, buf_rready_o, buf_rbe_o, wr_valid_o, wr_strb_o}, 64'd0);
    chk("rw_async_wr", {wr_addr_o, wr_data_o}, 64'd0);
    buf_rvalid_i = 1'b1;
    buf_rdata_i  = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rw_hold_done", {63'd0, done_o}, 64'd0);
      chk("rw_hold_busy", {63'd0, busy_o}, 64'd0);
    end
    buf_rvalid_i = 1'b0;
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rw_rel_done", {63'd0, done_o}, 64'd0);
    chk("rw_rel_busy", {63'd0, busy_o}, 64'd0);
    start_xfer(32'h0000_0104, 16'd4);
    run_beat(4'b1111, 32'h0000_0104, 32'h2468_ACE0, 1, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_pop_ctrl.md
Name: dma_pop_ctrl

Overview:
- Destination-side reader of the per-channel DMA byte buffer.
- Accepts a transfer descriptor: destination byte address and byte length.
- Issues byte-enable read requests to the buffer's read port, one word per beat.
- Forwards each returned word to the destination write bus with the matching word-aligned address and strobe, handling an unaligned start and a partial last beat.

Parameters:
- DATA_WD, 32, data width of the buffer read port and the destination bus.
- BE_WD, DATA_WD/8, byte-enable/strobe width.
- ADDR_WD, 32, destination address width.
- LEN_WD, 16, transfer length width, in bytes.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  start pulse; sampled only in IDLE.
- dst_addr_i  input  ADDR_WD  destination byte address; any alignment.
- len_i  input  LEN_WD  transfer length in bytes.
- busy_o  output  1  high from the cycle after an accepted start until DONE exits.
- done_o  output  1  one-cycle pulse at transfer end.
- buf_rready_o  output  1  one-cycle buffer read request.
- buf_rbe_o  output  BE_WD  byte lanes requested; valid with buf_rready_o.
- buf_rvalid_i  input  1  one-cycle pulse from the buffer; data is valid in that cycle.
- buf_rdata_i  input  DATA_WD  returned word; requested bytes sit in their rbe lanes.
- wr_valid_o  output  1  destination write valid.
- wr_addr_o  output  ADDR_WD  word-aligned write address (low log2(BE_WD) bits are 0).
- wr_data_o  output  DATA_WD  write data.
- wr_strb_o  output  BE_WD  write byte strobe.
- wr_ready_i  input  1  destination write ready.

Behaviour:
- Reset values: all outputs 0. Internal address, remaining count and data register are cleared; FSM goes to IDLE.
- Reset asserted mid-transfer aborts immediately. No done_o. On release the block sits in IDLE.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE. All outputs are registered or decoded from state and registers; no comb path from inputs to outputs.
- IDLE, start_i=1, len_i!=0: latch addr=dst_addr_i and rem=len_i, go to REQ.
- IDLE, start_i=1, len_i==0: go to DONE; no buffer request is issued.
- Any other state: start_i is ignored.
- REQ (exactly 1 cycle): buf_rready_o=1, buf_rbe_o=strb, then go to WAIT.
  - off = addr[log2(BE_WD)-1:0]
  - nb = min(BE_WD-off, rem)
  - strb = ((1<<nb)-1) << off
- Latency: start_i accepted in cycle N gives buf_rready_o high in cycle N+1.
- WAIT: hold until buf_rvalid_i=1. Then capture buf_rdata_i, masked to strb (unrequested lanes forced to 0), and go to WRITE. Wait is unbounded; there is no timeout.
- buf_rvalid_i in any state other than WAIT is ignored and changes no register.
- WRITE: wr_valid_o=1, wr_addr_o = addr with low bits cleared, wr_data_o=captured data, wr_strb_o=strb. All four stay stable until wr_valid_o && wr_ready_i.
  - On that fire: addr <= aligned addr + BE_WD; rem <= rem - nb.
  - New rem==0 goes to DONE; otherwise go to REQ.
- Only one beat is ever outstanding: no new buffer request is made while WRITE is back-pressured.
- DONE (1 cycle): done_o=1, busy_o=1, then go to IDLE. busy_o drops in the IDLE cycle that follows.
- Arithmetic:
  - rem is LEN_WD bits; nb is log2(BE_WD)+1 bits.
  - The address increment wraps modulo 2^ADDR_WD with no error.
- Beats per transfer = ceil((off0+len)/BE_WD).

Decomposition:
- Shared DMA package holds:
  - the pop FSM state enum (IDLE/REQ/WAIT/WRITE/DONE), 3-bit encoded;
  - the byte-lane offset width localparam.
- One natural sub-module, dma_strb_gen: a combinational off/rem to nb/strb generator. It is reusable by the push side.

Test Plan:
- Aligned: addr 0x100, len 8, wr_ready_i=1 → 2 buffer requests, rbe 1111 each; writes (0x100,1111) then (0x104,1111); done_o pulses once after the second write fire.
- Unaligned: addr 0x103, len 6 → rbe/strb sequence 1000@0x100, 1111@0x104, 0001@0x108; unrequested data lanes are 0.
- Sub-word: addr 0x102, len 1 → single beat, strb 0100 @0x100; done_o 1 cycle after the write fire.
- Back-pressure: wr_ready_i low 5 cycles during beat 1 of a len-8 transfer → wr_valid/addr/data/strb held constant; buf_rready_o stays 0 until the fire; stray buf_rvalid_i pulses in WRITE are ignored.
- Zero length, and start while busy: len 0 → done_o in the cycle after start, no buf_rready_o. start_i pulsed mid-transfer → no effect on the beat sequence.
- Reset mid-transfer: rstn_i low in WAIT → all outputs 0 asynchronously, no done_o; a new start after release completes normally.
